// File: rtl/axi_lite_regbank_pkg.sv
// Shared types and constants for the AXI4-Lite register bank.
package axi_lite_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Number of byte-offset address bits below the word index.
  function automatic int addr_lsb(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axi_lite_regbank_irq.sv
// Sticky interrupt status with W1C clear, enable mask and registered IRQ.
module axi_lite_regbank_irq #(
  parameter int DATA_W    = 32,
  parameter int IRQ_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IRQ_WIDTH-1:0] irq_src_i,
  input  logic [IRQ_WIDTH-1:0] stat_clr_i,
  input  logic                 en_we_i,
  input  logic [DATA_W-1:0]    en_wdata_i,
  output logic [IRQ_WIDTH-1:0] stat_o,
  output logic [DATA_W-1:0]    en_o,
  output logic                 irq_o
);

  logic [IRQ_WIDTH-1:0] stat_q, stat_d;
  logic [DATA_W-1:0]    en_q, en_d;
  logic                 irq_q;

  // Next state: clear is applied first so a same-edge source assertion wins.
  always_comb begin
    stat_d = (stat_q & ~stat_clr_i) | irq_src_i;
    en_d   = en_we_i ? en_wdata_i : en_q;
  end

  // Status/enable registers and the one-cycle-late IRQ output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_q <= '0;
      en_q   <= '0;
      irq_q  <= 1'b0;
    end else begin
      stat_q <= stat_d;
      en_q   <= en_d;
      irq_q  <= |(stat_q & en_q[IRQ_WIDTH-1:0]);
    end
  end

  assign stat_o = stat_q;
  assign en_o   = en_q;
  assign irq_o  = irq_q;

endmodule

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: RW control regs, RO status regs, W1C IRQ status.
module axi_lite_regbank
  import axi_lite_regbank_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_RW             = 4,
  parameter int NUM_RO             = 2,
  parameter int IRQ_WIDTH          = 8
) (
  input  logic                                 s00_axi_aclk,
  input  logic                                 s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        s00_axi_awaddr,
  input  logic [2:0]                           s00_axi_awprot,
  input  logic                                 s00_axi_awvalid,
  output logic                                 s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      s00_axi_wstrb,
  input  logic                                 s00_axi_wvalid,
  output logic                                 s00_axi_wready,
  output logic [1:0]                           s00_axi_bresp,
  output logic                                 s00_axi_bvalid,
  input  logic                                 s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        s00_axi_araddr,
  input  logic [2:0]                           s00_axi_arprot,
  input  logic                                 s00_axi_arvalid,
  output logic                                 s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        s00_axi_rdata,
  output logic [1:0]                           s00_axi_rresp,
  output logic                                 s00_axi_rvalid,
  input  logic                                 s00_axi_rready,
  output logic [NUM_RW*C_S_AXI_DATA_WIDTH-1:0] ctrl_out,
  output logic [NUM_RW-1:0]                    ctrl_wr_pulse,
  input  logic [NUM_RO*C_S_AXI_DATA_WIDTH-1:0] status_in,
  input  logic [IRQ_WIDTH-1:0]                 irq_in,
  output logic                                 irq
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int SW       = DW / 8;
  localparam int ADDR_LSB = addr_lsb(DW);
  localparam int IDX_W    = AW - ADDR_LSB;
  localparam int IDX_STAT = NUM_RW + NUM_RO;
  localparam int IDX_EN   = IDX_STAT + 1;
  localparam int NUM_REGS = NUM_RW + NUM_RO + 2;

  function automatic logic [DW-1:0] strb_mask(input logic [SW-1:0] s);
    logic [DW-1:0] m;
    for (int k = 0; k < SW; k++) m[k*8 +: 8] = {8{s[k]}};
    return m;
  endfunction

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;
  logic          aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d, wr_resp, rd_resp;
  logic [DW-1:0] rdata_q, rdata_d, rd_data;
  logic [DW-1:0] rw_q [NUM_RW];
  logic [DW-1:0] rw_d [NUM_RW];
  logic [NUM_RW-1:0] pulse_q, pulse_d;
  logic          aw_hs, w_hs, do_write, en_we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data, wr_mask, clr_full, en_q, en_wdata;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [IRQ_WIDTH-1:0] stat_clr, stat_q;
  logic          unused_ok;

  assign s00_axi_awready = (wr_state_q == W_IDLE) && !aw_held_q;
  assign s00_axi_wready  = (wr_state_q == W_IDLE) && !w_held_q;
  assign s00_axi_arready = (rd_state_q == R_IDLE);
  assign aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign w_hs  = s00_axi_wvalid && s00_axi_wready;

  // A freshly handshaken beat is used directly so same-cycle AW+W writes at once.
  assign wr_addr  = aw_held_q ? awaddr_q : s00_axi_awaddr;
  assign wr_data  = w_held_q ? wdata_q : s00_axi_wdata;
  assign wr_mask  = strb_mask(w_held_q ? wstrb_q : s00_axi_wstrb);
  assign wr_idx   = wr_addr[AW-1:ADDR_LSB];
  assign rd_idx   = s00_axi_araddr[AW-1:ADDR_LSB];
  assign clr_full = wr_data & wr_mask;
  assign en_wdata = (en_q & ~wr_mask) | (wr_data & wr_mask);
  assign wr_resp  = (int'(wr_idx) < NUM_RW || int'(wr_idx) == IDX_STAT ||
                     int'(wr_idx) == IDX_EN) ? RESP_OKAY : RESP_SLVERR;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[ADDR_LSB-1:0], s00_axi_araddr[ADDR_LSB-1:0]};

  // Write channel: latch AW/W independently, perform the write once both are held.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    do_write   = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = s00_axi_awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s00_axi_wdata;
          wstrb_d  = s00_axi_wstrb;
        end
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          do_write   = 1'b1;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = wr_resp;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s00_axi_bready) begin
          bvalid_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Register-file next state and the per-register write pulse.
  always_comb begin
    pulse_d  = '0;
    en_we    = 1'b0;
    stat_clr = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      rw_d[i] = rw_q[i];
      if (do_write && int'(wr_idx) == i) begin
        rw_d[i]    = (rw_q[i] & ~wr_mask) | (wr_data & wr_mask);
        pulse_d[i] = 1'b1;
      end
    end
    if (do_write && int'(wr_idx) == IDX_EN)   en_we    = 1'b1;
    if (do_write && int'(wr_idx) == IDX_STAT) stat_clr = clr_full[IRQ_WIDTH-1:0];
  end

  // Read mux over the current (pre-write) register values.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_SLVERR;
    for (int i = 0; i < NUM_RW; i++) begin
      if (int'(rd_idx) == i) begin
        rd_data = rw_q[i];
        rd_resp = RESP_OKAY;
      end
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (int'(rd_idx) == NUM_RW + j) begin
        rd_data = status_in[j*DW +: DW];
        rd_resp = RESP_OKAY;
      end
    end
    if (int'(rd_idx) == IDX_STAT) begin
      rd_data = DW'(stat_q);
      rd_resp = RESP_OKAY;
    end
    if (int'(rd_idx) == IDX_EN) begin
      rd_data = en_q;
      rd_resp = RESP_OKAY;
    end
    if (int'(rd_idx) >= NUM_REGS) rd_data = '0;
  end

  // Read channel: capture data at the AR handshake, hold until rready.
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (s00_axi_arvalid) begin
          rdata_d    = rd_data;
          rresp_d    = rd_resp;
          rvalid_d   = 1'b1;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s00_axi_rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // All state registers; reset drops any pending response.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      rvalid_q   <= 1'b0;
      rresp_q    <= '0;
      rdata_q    <= '0;
      pulse_q    <= '0;
      for (int i = 0; i < NUM_RW; i++) rw_q[i] <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      pulse_q    <= pulse_d;
      for (int i = 0; i < NUM_RW; i++) rw_q[i] <= rw_d[i];
    end
  end

  axi_lite_regbank_irq #(
    .DATA_W    (DW),
    .IRQ_WIDTH (IRQ_WIDTH)
  ) u_irq (
    .clk_i      (s00_axi_aclk),
    .rst_i      (s00_axi_areset),
    .irq_src_i  (irq_in),
    .stat_clr_i (stat_clr),
    .en_we_i    (en_we),
    .en_wdata_i (en_wdata),
    .stat_o     (stat_q),
    .en_o       (en_q),
    .irq_o      (irq)
  );

  for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
    assign ctrl_out[g*DW +: DW] = rw_q[g];
  end

  assign ctrl_wr_pulse  = pulse_q;
  assign s00_axi_bvalid = bvalid_q;
  assign s00_axi_bresp  = bresp_q;
  assign s00_axi_rvalid = rvalid_q;
  assign s00_axi_rresp  = rresp_q;
  assign s00_axi_rdata  = rdata_q;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Self-checking bench for axi_lite_regbank against a behavioural register-map model.
module tb_axi_lite_regbank;

  localparam int DW = 32, AW = 6, NRW = 4, NRO = 2, IW = 8;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [NRW*DW-1:0] ctrl_out;
  logic [NRW-1:0] ctrl_wr_pulse;
  logic [NRO*DW-1:0] status_in;
  logic [IW-1:0] irq_in;
  logic irq;

  // Behavioural model of the register map
  logic [DW-1:0] rw_m [NRW];
  logic [DW-1:0] ro_m [NRO];
  logic [DW-1:0] en_m;
  logic [IW-1:0] stat_m;
  int pulse_cnt [NRW];
  int exp_pulse [NRW];
  int total = 0;
  int bad = 0;

  logic [DW-1:0] d;
  logic [1:0] r;

  assign status_in = {ro_m[1], ro_m[0]};

  always #5 clk = ~clk;

  axi_lite_regbank #(
    .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW),
    .NUM_RW(NRW), .NUM_RO(NRO), .IRQ_WIDTH(IW)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .ctrl_out(ctrl_out), .ctrl_wr_pulse(ctrl_wr_pulse),
    .status_in(status_in), .irq_in(irq_in), .irq(irq)
  );

  always @(negedge clk) begin
    for (int i = 0; i < NRW; i++) if (ctrl_wr_pulse[i]) pulse_cnt[i]++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] bytemask(input logic [3:0] s);
    logic [DW-1:0] m;
    for (int k = 0; k < 4; k++) m[k*8 +: 8] = s[k] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic logic model_irq();
    return |(stat_m & en_m[IW-1:0]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NRW; i++) rw_m[i] = '0;
    en_m = '0;
    stat_m = '0;
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] dd, input logic [3:0] s,
                             output logic [1:0] eresp, output logic [NRW-1:0] epulse);
    int idx;
    logic [DW-1:0] m;
    idx = int'(a) / 4;
    m = bytemask(s);
    eresp = 2'b00;
    epulse = '0;
    if (idx < NRW) begin
      rw_m[idx] = (rw_m[idx] & ~m) | (dd & m);
      epulse[idx] = 1'b1;
      exp_pulse[idx]++;
    end else if (idx < NRW + NRO) eresp = 2'b10;
    else if (idx == NRW + NRO) stat_m = stat_m & ~(dd[IW-1:0] & m[IW-1:0]);
    else if (idx == NRW + NRO + 1) en_m = (en_m & ~m) | (dd & m);
    else eresp = 2'b10;
  endtask

  task automatic model_read(input logic [AW-1:0] a, output logic [DW-1:0] ed, output logic [1:0] er);
    int idx;
    idx = int'(a) / 4;
    er = 2'b00;
    ed = '0;
    if (idx < NRW) ed = rw_m[idx];
    else if (idx < NRW + NRO) ed = ro_m[idx - NRW];
    else if (idx == NRW + NRO) ed = {{(DW-IW){1'b0}}, stat_m};
    else if (idx == NRW + NRO + 1) ed = en_m;
    else er = 2'b10;
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] dd, input logic [3:0] s,
                           input logic [IW-1:0] irqp, output logic [1:0] resp,
                           output logic [NRW-1:0] pls);
    bit aw_done, w_done, a_acc, w_acc;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    awaddr = a; wdata = dd; wstrb = s; awvalid = 1; wvalid = 1; bready = 1; irq_in = irqp;
    while (!(aw_done && w_done) && n < 20) begin
      a_acc = awvalid && awready;
      w_acc = wvalid && wready;
      step();
      irq_in = '0;
      if (a_acc) begin aw_done = 1; awvalid = 0; end
      if (w_acc) begin w_done = 1; wvalid = 0; end
      n++;
    end
    awvalid = 0; wvalid = 0;
    n = 0;
    while (!bvalid && n < 20) begin step(); n++; end
    check("bvalid_seen", bvalid, 1'b1);
    resp = bresp;
    pls = ctrl_wr_pulse;
    step();
    bready = 0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] dd, output logic [1:0] resp);
    bit acc;
    int n;
    araddr = a; arvalid = 1; rready = 1; n = 0;
    acc = 0;
    while (!acc && n < 20) begin
      acc = arready;
      step();
      n++;
    end
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 20) begin step(); n++; end
    check("rvalid_seen", rvalid, 1'b1);
    dd = rdata;
    resp = rresp;
    step();
    rready = 0;
  endtask

  task automatic do_wr(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] dd,
                       input logic [3:0] s, input logic [IW-1:0] irqp);
    logic [1:0] eresp, resp;
    logic [NRW-1:0] epulse, pls;
    model_write(a, dd, s, eresp, epulse);
    stat_m = stat_m | irqp;
    axi_write(a, dd, s, irqp, resp, pls);
    check({tag, "_bresp"}, resp, eresp);
    check({tag, "_pulse"}, pls, epulse);
    check({tag, "_irq"}, irq, model_irq());
  endtask

  task automatic do_rd(input string tag, input logic [AW-1:0] a, output logic [DW-1:0] dd);
    logic [DW-1:0] ed;
    logic [1:0] er, resp;
    model_read(a, ed, er);
    axi_read(a, dd, resp);
    check({tag, "_rdata"}, dd, ed);
    check({tag, "_rresp"}, resp, er);
  endtask

  task automatic irq_pulse(input logic [IW-1:0] v);
    irq_in = v;
    stat_m = stat_m | v;
    step();
    irq_in = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 0; araddr = '0; arprot = '0; arvalid = 0; rready = 0; irq_in = '0;
    for (int i = 0; i < NRW; i++) begin pulse_cnt[i] = 0; exp_pulse[i] = 0; end
    ro_m[0] = '0; ro_m[1] = '0;
    model_reset();
    step(); step();
    check("rst_awready", awready, 1'b1);
    check("rst_wready", wready, 1'b1);
    check("rst_arready", arready, 1'b1);
    check("rst_valids", {bvalid, rvalid, irq}, 3'b000);
    check("rst_resp_data", {bresp, rresp, rdata}, '0);
    check("rst_ctrl", {ctrl_out, ctrl_wr_pulse}, '0);
    rst = 0;
    step();

    // Basic writes and readback
    for (int i = 0; i < 4; i++) do_wr("basic_wr", AW'(i * 4), DW'(i + 1), 4'hF, '0);
    for (int i = 0; i < 4; i++) do_rd("basic_rd", AW'(i * 4), d);
    for (int i = 0; i < NRW; i++) check("basic_pulse_cnt", pulse_cnt[i], 1);
    check("basic_ctrl_out", ctrl_out, {32'd4, 32'd3, 32'd2, 32'd1});

    // Byte strobes
    do_wr("strb_full", 6'h00, 32'h11223344, 4'hF, '0);
    do_wr("strb_part", 6'h00, 32'hAABBCCDD, 4'b0101, '0);
    do_rd("strb_rd", 6'h00, d);
    check("strb_const", d, 32'h11BB33DD);

    // W three cycles ahead of AW, bready held off
    wdata = 32'hDEAD0004; wstrb = 4'hF; wvalid = 1; awvalid = 0; bready = 0;
    step();
    wvalid = 0;
    check("wfirst_wready_low", wready, 1'b0);
    check("wfirst_awready_high", awready, 1'b1);
    step(); step();
    check("wfirst_no_bvalid", bvalid, 1'b0);
    awaddr = 6'h04; awvalid = 1;
    step();
    awvalid = 0;
    model_write(6'h04, 32'hDEAD0004, 4'hF, r, ctrl_wr_pulse_dummy);
    check("wfirst_bvalid", {bvalid, bresp}, {1'b1, r});
    check("wfirst_ready_low", {awready, wready}, 2'b00);
    for (int k = 0; k < 5; k++) begin
      step();
      check("wfirst_hold", {bvalid, bresp, awready, wready}, {1'b1, 2'b00, 2'b00});
    end
    bready = 1;
    step();
    bready = 0;
    check("wfirst_done", {bvalid, awready, wready}, 3'b011);
    do_rd("wfirst_rd", 6'h04, d);

    // Read-only status and out-of-range
    ro_m[0] = 32'hCAFEF00D; ro_m[1] = 32'h0BADBEEF;
    do_rd("ro_rd", 6'h10, d);
    check("ro_const", d, 32'hCAFEF00D);
    do_wr("ro_wr", 6'h10, 32'h12345678, 4'hF, '0);
    do_rd("ro_rd_after", 6'h10, d);
    do_rd("oor_rd", 6'h20, d);
    do_wr("oor_wr", 6'h24, 32'hFFFFFFFF, 4'hF, '0);

    // Interrupts
    do_wr("irq_en", 6'h1C, 32'h00000004, 4'hF, '0);
    irq_pulse(8'h04);
    step();
    check("irq_set", irq, 1'b1);
    do_rd("irq_stat_rd", 6'h18, d);
    check("irq_stat_const", d, 32'h4);
    do_wr("irq_clr", 6'h18, 32'h00000004, 4'hF, '0);
    check("irq_clr_low", irq, 1'b0);
    do_rd("irq_stat_clr_rd", 6'h18, d);
    irq_pulse(8'h04);
    do_wr("irq_clr_set", 6'h18, 32'h00000004, 4'hF, 8'h04);
    do_rd("irq_clr_set_rd", 6'h18, d);
    check("irq_clr_set_const", d, 32'h4);

    // Randomised traffic against the model
    ro_m[0] = $urandom; ro_m[1] = $urandom;
    for (int t = 0; t < 80; t++) begin
      logic [3:0] idx;
      logic [1:0] lo;
      logic [AW-1:0] a;
      idx = 4'($urandom_range(0, 9));
      lo = 2'($urandom);
      a = {idx, lo};
      if ($urandom_range(0, 1) == 1) irq_pulse(IW'($urandom));
      if ($urandom_range(0, 1) == 1) do_wr("rnd_wr", a, $urandom, 4'($urandom), '0);
      else do_rd("rnd_rd", a, d);
      check("rnd_irq", irq, model_irq());
    end
    check("rnd_ctrl_out", ctrl_out, {rw_m[3], rw_m[2], rw_m[1], rw_m[0]});
    for (int i = 0; i < NRW; i++) check("pulse_total", pulse_cnt[i], exp_pulse[i]);

    // Reset while both responses are pending
    awaddr = 6'h00; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    araddr = 6'h00; arvalid = 1; rready = 0;
    step();
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("mid_pending", {bvalid, rvalid}, 2'b11);
    #2 rst = 1;
    #1;
    check("mid_rst_drop", {bvalid, rvalid}, 2'b00);
    check("mid_rst_ctrl", ctrl_out, '0);
    model_reset();
    #3 rst = 0;
    bready = 1; rready = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("mid_no_resp", {bvalid, rvalid}, 2'b00);
    end
    bready = 0; rready = 0;
    do_rd("mid_rd", 6'h00, d);
    check("mid_rd_const", d, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  logic [NRW-1:0] ctrl_wr_pulse_dummy;

endmodule

// File: doc/axi_lite_regbank.md
Name: axi_lite_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; next generation of the fixed 4-register slave interface used by the SD-card peripheral.
- Generalises the register count and data width.
- Adds per-byte write strobes, read-only status registers fed by user logic, a write-1-to-clear interrupt status register with enable mask and IRQ output, and SLVERR responses.
- Sits between the AXI interconnect and peripheral core logic (SD-card controller and later peripherals).

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; must be 32 or 64.
- C_S_AXI_ADDR_WIDTH, 6, byte address width; must cover NUM_REGS words.
- NUM_RW, 4, number of read/write control registers.
- NUM_RO, 2, number of read-only status registers.
- IRQ_WIDTH, 8, number of interrupt sources; must be ≤ C_S_AXI_DATA_WIDTH.

Ports:
- s00_axi_aclk  in  1  clock
- s00_axi_areset  in  1  asynchronous active-high reset
- s00_axi_awaddr/awprot/awvalid/awready  in/in/in/out  ADDR_W/3/1/1  write address channel
- s00_axi_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_W/DATA_W/8/1/1  write data channel
- s00_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel
- s00_axi_araddr/arprot/arvalid/arready  in/in/in/out  ADDR_W/3/1/1  read address channel
- s00_axi_rdata/rresp/rvalid/rready  out/out/out/in  DATA_W/2/1/1  read data channel
- ctrl_out  out  NUM_RW*DATA_W  flattened RW register contents; reg i at slice i.
- ctrl_wr_pulse  out  NUM_RW  one-cycle pulse when reg i is written.
- status_in  in  NUM_RO*DATA_W  live read-only values.
- irq_in  in  IRQ_WIDTH  level interrupt sources.
- irq  out  1  registered interrupt request.

Behaviour:
- Register map (word index = addr[ADDR_W-1:ADDR_LSB], with ADDR_LSB = clog2(DATA_W/8); low address bits are ignored):
  - 0..NUM_RW-1: RW registers.
  - NUM_RW..NUM_RW+NUM_RO-1: RO registers.
  - next index: IRQ_STAT (W1C).
  - next index: IRQ_EN (RW).
  - NUM_REGS = NUM_RW+NUM_RO+2.
- Reset values: all registers 0. awready/wready = 1. bvalid, rvalid, irq, ctrl_wr_pulse = 0. bresp, rresp, rdata = 0.
- Write channel FSM:
  - States: W_IDLE, W_RESP.
  - In W_IDLE, AW and W are accepted independently and latched. awready drops once AW is held; wready drops once W is held.
  - The cycle both are held, the write is performed, bvalid=1, and the FSM enters W_RESP.
  - bvalid stays high with bresp stable until bready. The handshake cycle returns to W_IDLE with awready=wready=1 on the next cycle.
  - Same-cycle AW+W from idle gives bvalid 1 cycle later. One outstanding write.
- Write effect:
  - RW and IRQ_EN: byte lane k is updated iff wstrb[k]. bresp=OKAY.
  - IRQ_STAT: bits with wdata&strobe-mask = 1 are cleared. bresp=OKAY.
  - RO index: no effect, bresp=SLVERR (2'b10).
  - Index ≥ NUM_REGS: no effect, SLVERR.
  - ctrl_wr_pulse[i] is asserted the cycle after the write edge for RW regs only, and even if wstrb=0.
- Read channel FSM:
  - States: R_IDLE, R_DATA.
  - arready=1 in R_IDLE. On handshake, rdata/rresp are registered from the current register value, rvalid=1 next cycle.
  - rdata/rresp are held stable until rready, then the FSM returns to R_IDLE.
  - Out-of-range reads return rdata=0, SLVERR.
  - RO reads sample status_in at the AR handshake edge.
- Simultaneous read and write to the same register on one edge: read returns the pre-write value.
- IRQ:
  - Every cycle: IRQ_STAT[n] |= irq_in[n]. Bits above IRQ_WIDTH read 0.
  - If set and W1C clear hit the same bit on the same edge, set wins.
  - irq = |(IRQ_STAT & IRQ_EN), registered with 1 cycle latency.
- Reset mid-transaction: all state returns to reset values immediately and asynchronously. Pending responses are dropped and registers cleared.
- awprot/arprot are ignored.

Decomposition:
- Package axi_lite_regbank_pkg:
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - FSM state enums wr_state_t and rd_state_t.
  - function addr_lsb(data_w).
- One sub-module, axi_lite_regbank_irq: sticky status, W1C clear, enable mask, registered irq output.

Test Plan:
- Write 0x00000001..0x00000004 to 0x0,0x4,0x8,0xC, then read back -> equal data, all resp OKAY, ctrl_wr_pulse pulses once per write.
- Write 0xAABBCCDD to 0x0 with wstrb=4'b0101 over 0x11223344 -> readback 0x11BB33DD.
- W presented 3 cycles before AW, bready held low 5 cycles -> bvalid 1 cycle after AW; bvalid/bresp stable until bready; awready/wready low while pending.
- status_in reg0=0xCAFEF00D, read 0x10 -> 0xCAFEF00D OKAY. Write 0x10 -> SLVERR, no change. Read 0x20 -> 0x0 SLVERR.
- irq_in[2] pulses 1 cycle with IRQ_EN=0x04 -> IRQ_STAT=0x04, irq=1. Write 0x04 to 0x18 -> IRQ_STAT=0, irq=0 next cycle. Clear and set on the same cycle -> bit stays 1.
- Assert reset while bvalid=1 and rvalid=1 -> both drop immediately. Reg 0x0 reads 0 after release. No response is emitted for the dropped transactions.
